inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, SHALL be the first fetch address after reset.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 stall  in  1  decode stage not accepting; the slot is consumed when id_valid=1 and stall=0.
REQ-005 redirect  in  1  branch/jump taken; flush and refetch.
REQ-006 redirect_pc  in  32  new fetch address; bits [1:0] SHALL be ignored and treated as 00.
REQ-007 imem_req  out  1  instruction-memory request.
REQ-008 imem_addr  out  32  word address of the outstanding request.
REQ-009 imem_ack  in  1  single-cycle response strobe; imem_rdata is valid in the same cycle.
REQ-010 imem_rdata  in  32  instruction word.
REQ-011 id_valid  out  1  output slot holds a valid instruction.
REQ-012 id_pc  out  32  address of id_instr.
REQ-013 id_instr  out  32  fetched instruction.
REQ-014 id_imm  out  16  id_instr[15:0]; drives the immediate extend unit.
REQ-015 id_ext_src  out  1  extend-unit select: 1 = sign extend, 0 = zero extend.

Function
REQ-016 The FSM SHALL have three states: S_IDLE (no request), S_REQ (request outstanding), S_DROP (outstanding request to be discarded).
REQ-017 imem_req SHALL be 1 exactly in S_REQ and S_DROP; imem_addr SHALL be the req_addr register and SHALL stay stable until imem_ack.
REQ-018 S_IDLE with redirect=1: pc <= redirect_pc; remain in S_IDLE.
REQ-019 S_IDLE with redirect=0 and (id_valid=0 or stall=0): req_addr <= pc; go to S_REQ.
REQ-020 S_IDLE with redirect=0, id_valid=1 and stall=1: hold all state.
REQ-021 S_REQ with imem_ack=1 and redirect=0: id_instr <= imem_rdata, id_pc <= req_addr, id_valid <= 1, pc <= req_addr+4 (modulo 2^32, wraps to 0); go to S_IDLE.
REQ-022 S_REQ with redirect=1 and imem_ack=0: pc <= redirect_pc; go to S_DROP.
REQ-023 S_REQ with redirect=1 and imem_ack=1: discard the data, pc <= redirect_pc, id_valid unchanged at 0; go to S_IDLE.
REQ-024 S_DROP: on imem_ack, discard the data and go to S_IDLE; a redirect in S_DROP SHALL update pc only.
REQ-025 id_valid SHALL clear on the edge where id_valid=1 and stall=0, or where redirect=1; redirect takes priority over stall.
REQ-026 The slot SHALL be empty whenever the FSM is in S_REQ, so an ack never collides with a held instruction.
REQ-027 Latency: with a memory that acks one cycle after imem_req rises, id_valid SHALL rise 2 cycles after entry to S_IDLE; sustained throughput SHALL be 1 instruction per 2 cycles.
REQ-028 id_ext_src SHALL be 1 when id_instr[31:26] is one of 08, 09, 0A, 0B, 23, 2B, 04 or 05 (hex); it SHALL be 0 otherwise (for example 0C, 0D, 0E, 0F).

Reset
REQ-029 While rst_n=0, the block SHALL hold state=S_IDLE, pc=RESET_PC, req_addr=RESET_PC, id_valid=0, id_pc=0, id_instr=0 (so id_imm=0 and id_ext_src=0), and imem_req=0.
REQ-030 Reset asserted mid-request SHALL abandon the request with no pending discard; the first post-reset fetch SHALL be from RESET_PC.

Structure
REQ-031 A shared package SHALL hold the state encoding, the MIPS opcode constants and the RESET_PC default.
REQ-032 The opcode-to-ext_src decode SHALL be one combinational sub-module, ext_ctrl.

Verification
REQ-033 Reset release, memory acks 1 cycle after req -> first imem_addr=0000_3000, then 0000_3004; id_valid pulses every 2 cycles.
REQ-034 stall held 5 cycles with id_valid=1 -> imem_req stays 0; id_instr/id_pc stay stable; fetch resumes the cycle after stall drops.
REQ-035 redirect to 0000_4002 while in S_REQ, ack 3 cycles later -> that data is dropped; the next imem_addr is 0000_4000; no id_valid for the dropped word.
REQ-036 redirect and imem_ack in the same cycle -> data dropped; next fetch from redirect_pc; redirect with id_valid=1 and stall=1 -> id_valid clears.
REQ-037 id_instr opcodes 08/0D/23/0F -> id_ext_src = 1/0/1/0; id_imm = id_instr[15:0].
REQ-038 pc=FFFF_FFFC fetched -> next imem_addr is 0000_0000; rst_n pulsed low in S_DROP -> next fetch from RESET_PC.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// MIPS opcode constants and the default reset fetch address.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface inst_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/inst_fetch_ext_ctrl.sv
// Immediate extend-mode decode: arithmetic-immediate, load/store and branch
// opcodes sign-extend, everything else (logical immediates, lui) zero-extends.
module ext_ctrl
  import inst_fetch_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       ext_src
);

  always_comb begin
    ext_src = 1'b0;
    case (opcode)
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_LW, OP_SW, OP_BEQ, OP_BNE: ext_src = 1'b1;
      default:                      ext_src = 1'b0;
    endcase
  end

endmodule

// File: rtl/inst_fetch.sv
// Single-slot instruction fetch stage: issues one memory request at a time,
// holds the returned word for decode, and discards responses made stale by a redirect.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  inst_fetch_if.master       imem,
  output logic               id_valid,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_instr,
  output logic [15:0]        id_imm,
  output logic               id_ext_src
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  req_addr, req_addr_nxt;
  logic         valid_nxt;
  logic [31:0]  id_pc_nxt, id_instr_nxt;
  logic [31:0]  target;
  logic         unused_pc_bits;

  assign target         = {redirect_pc[31:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_instr <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      req_addr <= req_addr_nxt;
      id_valid <= valid_nxt;
      id_pc    <= id_pc_nxt;
      id_instr <= id_instr_nxt;
    end
  end

  // A new request is only launched once the slot is free or being consumed,
  // so the slot is always empty while a request is outstanding.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    req_addr_nxt = req_addr;
    valid_nxt    = id_valid;
    id_pc_nxt    = id_pc;
    id_instr_nxt = id_instr;

    if (redirect || (id_valid && !stall)) valid_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        if (redirect) begin
          pc_nxt = target;
        end else if (!id_valid || !stall) begin
          req_addr_nxt = pc;
          state_nxt    = S_REQ;
        end
      end
      S_REQ: begin
        if (redirect) begin
          pc_nxt    = target;
          state_nxt = imem.imem_ack ? S_IDLE : S_DROP;
        end else if (imem.imem_ack) begin
          id_instr_nxt = imem.imem_rdata;
          id_pc_nxt    = req_addr;
          valid_nxt    = 1'b1;
          pc_nxt       = next_word(req_addr);
          state_nxt    = S_IDLE;
        end
      end
      S_DROP: begin
        if (redirect)      pc_nxt    = target;
        if (imem.imem_ack) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign imem.imem_req  = (state == S_REQ) || (state == S_DROP);
  assign imem.imem_addr = req_addr;
  assign id_imm         = id_instr[15:0];

  ext_ctrl u_ext_ctrl (
    .opcode  (id_instr[31:26]),
    .ext_src (id_ext_src)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized traffic
// compared against a transaction-level model of the fetch slot.
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [15:0] id_imm;
  logic        id_ext_src;

  inst_fetch_if imem ();

  inst_fetch #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_instr    (id_instr),
    .id_imm      (id_imm),
    .id_ext_src  (id_ext_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  // Model: one outstanding request (possibly doomed by a redirect) and one decode slot.
  bit          mBusy;
  bit          mDoomed;
  bit          mSlotValid;
  logic [31:0] mNextPc;
  logic [31:0] mReqAddr;
  logic [31:0] mSlotPc;
  logic [31:0] mSlotInstr;

  logic [5:0] opTable [12] = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                               6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic expExtSrc(input logic [31:0] instr);
    case (instr[31:26])
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B, 6'h04, 6'h05: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] randInstr();
    logic [31:0] r;
    r = $urandom();
    return {opTable[$urandom_range(0, 11)], r[25:0]};
  endfunction

  task automatic checkAll();
    checkOutput("imem_req", {31'd0, imem.imem_req}, {31'd0, mBusy});
    if (mBusy) checkOutput("imem_addr", imem.imem_addr, mReqAddr);
    checkOutput("id_valid", {31'd0, id_valid}, {31'd0, mSlotValid});
    if (mSlotValid) begin
      checkOutput("id_pc", id_pc, mSlotPc);
      checkOutput("id_instr", id_instr, mSlotInstr);
      checkOutput("id_imm", {16'd0, id_imm}, {16'd0, mSlotInstr[15:0]});
      checkOutput("id_ext_src", {31'd0, id_ext_src}, {31'd0, expExtSrc(mSlotInstr)});
    end
  endtask

  // One clock: check current outputs, drive inputs, advance the model, step the clock.
  task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc,
                               input logic ack, input logic [31:0] rdata);
    logic ackq;
    logic oldValid;
    checkAll();
    ackq        = ack && mBusy;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem.imem_ack   = ackq;
    imem.imem_rdata = rdata;
    oldValid = mSlotValid;
    if (rd || (mSlotValid && !st)) mSlotValid = 1'b0;
    if (mBusy) begin
      if (ackq) begin
        if (!mDoomed && !rd) begin
          mSlotValid = 1'b1;
          mSlotPc    = mReqAddr;
          mSlotInstr = rdata;
          mNextPc    = mReqAddr + 32'd4;
        end
        mBusy   = 1'b0;
        mDoomed = 1'b0;
      end else if (rd) begin
        mDoomed = 1'b1;
      end
      if (rd) mNextPc = {rpc[31:2], 2'b00};
    end else if (rd) begin
      mNextPc = {rpc[31:2], 2'b00};
    end else if (!oldValid || !st) begin
      mBusy    = 1'b1;
      mReqAddr = mNextPc;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    imem.imem_ack = 1'b0;
    #1;
    mBusy = 1'b0;
    mDoomed = 1'b0;
    mSlotValid = 1'b0;
    mNextPc = RST_PC;
    checkOutput("rst_imem_req", {31'd0, imem.imem_req}, 32'd0);
    checkOutput("rst_id_valid", {31'd0, id_valid}, 32'd0);
    checkOutput("rst_id_pc", id_pc, 32'd0);
    checkOutput("rst_id_instr", id_instr, 32'd0);
    checkOutput("rst_id_imm", {16'd0, id_imm}, 32'd0);
    checkOutput("rst_id_ext_src", {31'd0, id_ext_src}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic runFree(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, randInstr());
  endtask

  task automatic waitBusy();
    for (int i = 0; i < 4 && !mBusy; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, randInstr());
    checkOutput("reach_busy", {31'd0, mBusy}, 32'd1);
  endtask

  initial begin
    logic [5:0]  dirOps [4] = '{6'h08, 6'h0D, 6'h23, 6'h0F};
    logic [31:0] r;
    logic [31:0] rpc;
    rst_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    imem.imem_ack = 1'b0;
    imem.imem_rdata = '0;
    doReset();

    // Back-to-back fetch from RESET_PC with an always-ready memory.
    runFree(8);

    // Hold a valid instruction under stall for five cycles, then release.
    for (int i = 0; i < 4 && !mSlotValid; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, randInstr());
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, randInstr());
    runFree(4);

    // Redirect while a request is outstanding; the late ack must be dropped.
    waitBusy();
    applyStimulus(1'b0, 1'b1, 32'h0000_4002, 1'b0, randInstr());
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, randInstr());
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, randInstr());
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, randInstr());
    runFree(4);

    // Redirect coincident with ack, then redirect over a stalled valid slot.
    waitBusy();
    applyStimulus(1'b0, 1'b1, 32'h0000_5000, 1'b1, randInstr());
    for (int i = 0; i < 4 && !mSlotValid; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, randInstr());
    applyStimulus(1'b1, 1'b1, 32'h0000_6000, 1'b0, randInstr());
    runFree(4);

    // Extend-select decode for a fixed opcode sequence.
    for (int i = 0; i < 8; i++) begin
      r = $urandom();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, {dirOps[i / 2], r[25:0]});
    end

    // Address wrap at the top of memory.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, randInstr());
    runFree(6);

    // Reset while a discard is pending; fetch restarts cleanly at RESET_PC.
    waitBusy();
    applyStimulus(1'b0, 1'b1, 32'h0000_7000, 1'b0, randInstr());
    doReset();
    runFree(4);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rpc = $urandom();
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFFC | {30'd0, rpc[1:0]};
      applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, rpc,
                    $urandom_range(0, 1) == 1, randInstr());
    end
    checkAll();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
